// File: rtl/conv1_acc_drain.sv
// ---------------------------------------------------------------------------
// conv1_acc_drain
//
// Downstream stage of the conv1 layer1 dense datapath. Accumulates TAPS
// product vectors (LANES lanes x DW bits, signed) per output pixel with
// saturating adds. Each finished pixel is copied into a shadow (drain)
// buffer and sent out one channel per handshake to the conv1 output BRAM
// writer. Accumulation of the next pixel overlaps the drain of the current
// one. A pixel that finishes while the drain is still busy is parked in the
// accumulator (acc_full = 1) until the drain hands off its last word.
//
// Build option:
//   CONV1_RELU_EN  defined   -> out_data = max(shadow[ch], 0) (fused ReLU)
//                  undefined -> out_data = shadow[ch] (signed pass-through)
//   Accumulation and saturation are identical in both builds.
//
// Ports:
//   clk       in   clock
//   rst       in   synchronous reset, active-low
//   halt      in   global freeze: no accept, no drain handshake, state held
//   in_v      in   product vector valid
//   in_data   in   LANES*DW, lane k = in_data[DW*k +: DW]
//   acc_full  out  finished pixel parked in acc; upstream must stall
//   pix_done  out  one-cycle pulse when a pixel enters the shadow buffer
//   out_v     out  output word valid
//   out_rdy   in   writer ready
//   out_data  out  DW, channel result
//   out_addr  out  PIX_AW+6, {pixel index, channel index}
// ---------------------------------------------------------------------------
module conv1_acc_drain #(
    parameter int LANES  = 64,
    parameter int DW     = 16,
    parameter int TAPS   = 75,
    parameter int PIX_AW = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  halt,
    input  logic                  in_v,
    input  logic [LANES*DW-1:0]   in_data,
    output logic                  acc_full,
    output logic                  pix_done,
    output logic                  out_v,
    input  logic                  out_rdy,
    output logic [DW-1:0]         out_data,
    output logic [PIX_AW+5:0]     out_addr
);

    localparam int CW = 6;
    localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [TW-1:0] TAP_LAST = TW'(TAPS - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(LANES - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [TW-1:0]       r_tap_cnt;
    logic [CW-1:0]       r_ch;
    logic [PIX_AW-1:0]   r_pix_idx;
    logic                r_acc_full;
    logic                r_pix_done;

    logic                w_accept;
    logic                w_tap0;
    logic                w_final;
    logic                w_out_v;
    logic                w_hs;
    logic                w_last_hs;
    logic                w_drain_free;
    logic                w_load_new;
    logic                w_load_acc;
    logic                w_load;
    logic [DW-1:0]       w_shadow [LANES];
    logic [DW-1:0]       w_sel;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    assign w_accept  = in_v & ~halt & ~r_acc_full;
    assign w_tap0    = (r_tap_cnt == '0);
    assign w_final   = w_accept & (r_tap_cnt == TAP_LAST);

    // out_v is a function of registered state gated by halt, so the word
    // reappears unchanged when halt drops.
    assign w_out_v   = (r_state == S_DRAIN) & ~halt;
    assign w_hs      = w_out_v & out_rdy;
    assign w_last_hs = w_hs & (r_ch == CH_LAST);

    // The drain can take a new pixel if idle, or if it is handing off its
    // last word on this very edge (back-to-back pixels, no bubble).
    assign w_drain_free = (r_state == S_IDLE) | w_last_hs;

    // Two ways into the shadow buffer: the final tap goes straight in when
    // the drain is free; a parked pixel moves in on the last handshake.
    // They are exclusive because accepts are blocked while acc_full = 1.
    assign w_load_new = w_final & w_drain_free;
    assign w_load_acc = r_acc_full & w_last_hs;
    assign w_load     = w_load_new | w_load_acc;

    // ------------------------------------------------------------------
    // Per-lane accumulator and shadow register
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DW-1:0] r_acc;
            logic [DW-1:0] r_shadow;
            logic [DW-1:0] w_in;
            logic [DW:0]   w_sum;
            logic [DW-1:0] w_sum_sat;
            logic [DW-1:0] w_tap_val;

            assign w_in  = in_data[gi*DW +: DW];
            // One guard bit: overflow shows as disagreement of the top two.
            assign w_sum = {r_acc[DW-1], r_acc} + {w_in[DW-1], w_in};

            always_comb begin
                w_sum_sat = w_sum[DW-1:0];
                if (w_sum[DW] != w_sum[DW-1]) begin
                    w_sum_sat = w_sum[DW] ? {1'b1, {(DW-1){1'b0}}}
                                          : {1'b0, {(DW-1){1'b1}}};
                end
            end

            // Tap 0 overwrites whatever the previous pixel left behind.
            assign w_tap_val = w_tap0 ? w_in : w_sum_sat;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_acc    <= '0;
                    r_shadow <= '0;
                end else begin
                    if (w_accept) begin
                        r_acc <= w_tap_val;
                    end
                    if (w_load_new) begin
                        r_shadow <= w_tap_val;
                    end else if (w_load_acc) begin
                        r_shadow <= r_acc;
                    end
                end
            end

            assign w_shadow[gi] = r_shadow;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Counters and flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tap_cnt  <= '0;
            r_ch       <= '0;
            r_pix_idx  <= '0;
            r_acc_full <= 1'b0;
            r_pix_done <= 1'b0;
        end else begin
            // Every load condition already implies !halt, so this also
            // clears the pulse while frozen.
            r_pix_done <= w_load;

            if (w_accept) begin
                r_tap_cnt <= w_final ? '0 : r_tap_cnt + 1'b1;
            end

            if (w_final & ~w_drain_free) begin
                r_acc_full <= 1'b1;
            end else if (w_load_acc) begin
                r_acc_full <= 1'b0;
            end

            if (w_load) begin
                r_ch <= '0;
            end else if (w_hs) begin
                r_ch <= (r_ch == CH_LAST) ? '0 : r_ch + 1'b1;
            end

            // Natural wrap at 2^PIX_AW.
            if (w_last_hs) begin
                r_pix_idx <= r_pix_idx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Drain FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_load) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_last_hs & ~w_load) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: all derived from registers, so data/address hold while
    // the writer back-pressures.
    // ------------------------------------------------------------------
    assign w_sel = w_shadow[r_ch];

`ifdef CONV1_RELU_EN
    assign out_data = w_sel[DW-1] ? '0 : w_sel;
`else
    assign out_data = w_sel;
`endif

    assign out_addr = {r_pix_idx, r_ch};
    assign out_v    = w_out_v;
    assign acc_full = r_acc_full;
    assign pix_done = r_pix_done;

endmodule

// File: tb/tb_conv1_acc_drain.sv
// ---------------------------------------------------------------------------
// tb_conv1_acc_drain
//
// Two instances: u_dut_a with default parameters (ramp, saturation, halt,
// reset abort) and u_dut_b with TAPS = 8, PIX_AW = 2 (backpressure with a
// parked pixel, pixel index wrap). Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_conv1_acc_drain;

    localparam int LANES = 64;
    localparam int DW    = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic                  halt = 1'b0;
    logic                  in_v = 1'b0;
    logic [LANES*DW-1:0]   in_data = '0;
    logic                  out_rdy = 1'b1;
    logic                  a_acc_full, a_pix_done, a_out_v;
    logic [DW-1:0]         a_out_data;
    logic [15:0]           a_out_addr;

    // Instance B signals
    logic                  b_halt = 1'b0;
    logic                  b_in_v = 1'b0;
    logic [LANES*DW-1:0]   b_in_data = '0;
    logic                  b_out_rdy = 1'b1;
    logic                  b_acc_full, b_pix_done, b_out_v;
    logic [DW-1:0]         b_out_data;
    logic [7:0]            b_out_addr;

    conv1_acc_drain u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .halt     (halt),
        .in_v     (in_v),
        .in_data  (in_data),
        .acc_full (a_acc_full),
        .pix_done (a_pix_done),
        .out_v    (a_out_v),
        .out_rdy  (out_rdy),
        .out_data (a_out_data),
        .out_addr (a_out_addr)
    );

    conv1_acc_drain #(.TAPS(8), .PIX_AW(2)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .halt     (b_halt),
        .in_v     (b_in_v),
        .in_data  (b_in_data),
        .acc_full (b_acc_full),
        .pix_done (b_pix_done),
        .out_v    (b_out_v),
        .out_rdy  (b_out_rdy),
        .out_data (b_out_data),
        .out_addr (b_out_addr)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [DW-1:0] exp_words [LANES];

    typedef struct {
        logic [15:0] l0;
        logic [15:0] l1;
        logic [15:0] lr;
        logic [15:0] e0;
        logic [15:0] e1;
        logic [15:0] er;
    } vec_t;

    vec_t tbl [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] relu(input logic [15:0] x);
`ifdef CONV1_RELU_EN
        return x[15] ? 16'h0000 : x;
`else
        return x;
`endif
    endfunction

    function automatic logic [LANES*DW-1:0] mkvec(input logic [15:0] l0,
                                                  input logic [15:0] l1,
                                                  input logic [15:0] lr);
        logic [LANES*DW-1:0] v;
        v = '0;
        for (int k = 0; k < LANES; k++) begin
            v[k*DW +: DW] = (k == 0) ? l0 : ((k == 1) ? l1 : lr);
        end
        return v;
    endfunction

    function automatic logic [31:0] get_v(input bit sel);
        return sel ? 32'(b_out_v) : 32'(a_out_v);
    endfunction
    function automatic logic [31:0] get_done(input bit sel);
        return sel ? 32'(b_pix_done) : 32'(a_pix_done);
    endfunction
    function automatic logic [31:0] get_full(input bit sel);
        return sel ? 32'(b_acc_full) : 32'(a_acc_full);
    endfunction
    function automatic logic [31:0] get_data(input bit sel);
        return sel ? 32'(b_out_data) : 32'(a_out_data);
    endfunction
    function automatic logic [31:0] get_addr(input bit sel);
        return sel ? 32'(b_out_addr) : 32'(a_out_addr);
    endfunction

    task automatic set_in(input bit sel, input logic v, input logic [LANES*DW-1:0] vec);
        if (sel) begin
            b_in_v    = v;
            b_in_data = vec;
        end else begin
            in_v    = v;
            in_data = vec;
        end
    endtask

    // mode 0: partial pixel, 1: final tap with drain free, 2: final tap blocked
    task automatic feed(input bit sel, input logic [LANES*DW-1:0] vec,
                        input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            set_in(sel, 1'b1, vec);
            @(posedge clk);
            #1;
            if (i < n - 1 || mode == 0) begin
                check("pix_done_mid", get_done(sel), 32'd0);
            end
        end
        set_in(sel, 1'b0, '0);
        if (mode == 1) begin
            check("pix_done_latency", get_done(sel), 32'd1);
            check("out_v_latency", get_v(sel), 32'd1);
        end else if (mode == 2) begin
            check("acc_full_set", get_full(sel), 32'd1);
            check("pix_done_blocked", get_done(sel), 32'd0);
        end
    endtask

    // Collect 64 words starting at channel 0 (out_rdy already 1).
    task automatic drain(input bit sel, input int pix, input int halt_at, input int abort_at);
        for (int ch = 0; ch < LANES; ch++) begin
            if (ch == halt_at) begin
                halt = 1'b1;
                for (int h = 0; h < 5; h++) begin
                    @(posedge clk);
                    #1;
                    check("halt_out_v", 32'(a_out_v), 32'd0);
                    check("halt_addr", 32'(a_out_addr), 32'(pix * 64 + ch));
                    check("halt_data", 32'(a_out_data), 32'(exp_words[ch]));
                end
                halt = 1'b0;
                #1;
            end
            if (ch == abort_at) begin
                rst = 1'b0;
                @(posedge clk);
                #1;
                rst = 1'b1;
                check("abort_out_v", get_v(sel), 32'd0);
                check("abort_addr", get_addr(sel), 32'd0);
                check("abort_acc_full", get_full(sel), 32'd0);
                $display("dut %0d pixel %0d aborted by reset at ch %0d", sel, pix, ch);
                return;
            end
            check("drain_v", get_v(sel), 32'd1);
            check("drain_addr", get_addr(sel), 32'(pix * 64 + ch));
            check("drain_data", get_data(sel), 32'(exp_words[ch]));
            if (ch == 1) begin
                check("pix_done_pulse", get_done(sel), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        $display("dut %0d pixel %0d drained, %0d words", sel, pix, LANES);
    endtask

    task automatic fill_exp(input logic [15:0] v);
        for (int k = 0; k < LANES; k++) begin
            exp_words[k] = v;
        end
    endtask

    initial begin
        logic [LANES*DW-1:0] ramp_vec;
        logic [LANES*DW-1:0] ones_vec;

        tbl[0] = '{16'h0001, 16'h0001, 16'h0001, 16'h004B, 16'h004B, 16'h004B};
        tbl[1] = '{16'h4000, 16'hC000, 16'h0000, 16'h7FFF, 16'h8000, 16'h0000};
        tbl[2] = '{16'h0100, 16'hFFFF, 16'h0002, 16'h4B00, 16'hFFB5, 16'h0096};
        tbl[3] = '{16'h0200, 16'hFE00, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF};

        ones_vec = mkvec(16'h0001, 16'h0001, 16'h0001);
        ramp_vec = '0;
        for (int k = 0; k < LANES; k++) begin
            ramp_vec[k*DW +: DW] = 16'(k + 1);
        end

        // ---------------- reset state ----------------
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check("rst_out_v", get_v(s[0]), 32'd0);
            check("rst_out_data", get_data(s[0]), 32'd0);
            check("rst_out_addr", get_addr(s[0]), 32'd0);
            check("rst_acc_full", get_full(s[0]), 32'd0);
            check("rst_pix_done", get_done(s[0]), 32'd0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- table: ramp and saturation ----------------
        for (int i = 0; i < 4; i++) begin
            fill_exp(relu(tbl[i].er));
            exp_words[0] = relu(tbl[i].e0);
            exp_words[1] = relu(tbl[i].e1);
            feed(1'b0, mkvec(tbl[i].l0, tbl[i].l1, tbl[i].lr), 75, 1);
            drain(1'b0, i, -1, -1);
            check("idle_after_drain", 32'(a_out_v), 32'd0);
        end

        // ---------------- halt mid-drain at ch 20 ----------------
        for (int k = 0; k < LANES; k++) begin
            exp_words[k] = 16'(75 * (k + 1));
        end
        feed(1'b0, ramp_vec, 75, 1);
        drain(1'b0, 4, 20, -1);
        check("idle_after_halt", 32'(a_out_v), 32'd0);

        // ---------------- reset at ch 30, then reset mid-accumulation ----------------
        fill_exp(16'h004B);
        feed(1'b0, ones_vec, 75, 1);
        drain(1'b0, 5, -1, 30);
        repeat (2) @(posedge clk);
        #1;
        check("post_reset_out_v", 32'(a_out_v), 32'd0);
        feed(1'b0, ones_vec, 10, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        feed(1'b0, ones_vec, 75, 1);
        drain(1'b0, 0, -1, -1);
        check("idle_after_reset_pix", 32'(a_out_v), 32'd0);

        // ---------------- B: backpressure with a parked pixel ----------------
        b_out_rdy = 1'b0;
        fill_exp(16'd8);
        feed(1'b1, mkvec(16'd1, 16'd1, 16'd1), 8, 1);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("stall_out_v", 32'(b_out_v), 32'd1);
            check("stall_addr", 32'(b_out_addr), 32'd0);
            check("stall_data", 32'(b_out_data), 32'd8);
        end
        feed(1'b1, mkvec(16'd2, 16'd2, 16'd2), 8, 2);
        check("stall_addr_parked", 32'(b_out_addr), 32'd0);
        // in_v while acc_full must not count as taps
        for (int g = 0; g < 3; g++) begin
            set_in(1'b1, 1'b1, mkvec(16'h1000, 16'h1000, 16'h1000));
            @(posedge clk);
            #1;
            check("acc_full_hold", 32'(b_acc_full), 32'd1);
        end
        set_in(1'b1, 1'b0, '0);
        b_out_rdy = 1'b1;
        drain(1'b1, 0, -1, -1);
        check("b2b_pix_done", 32'(b_pix_done), 32'd1);
        check("b2b_acc_full", 32'(b_acc_full), 32'd0);
        check("b2b_out_v", 32'(b_out_v), 32'd1);
        check("b2b_addr", 32'(b_out_addr), 32'h40);
        fill_exp(16'd16);
        drain(1'b1, 1, -1, -1);
        check("b_idle", 32'(b_out_v), 32'd0);
        // A counted garbage tap would end this pixel early (pix_done_mid).
        fill_exp(16'd24);
        feed(1'b1, mkvec(16'd3, 16'd3, 16'd3), 8, 1);
        drain(1'b1, 2, -1, -1);

        // ---------------- B: pixel index wrap ----------------
        fill_exp(16'd32);
        feed(1'b1, mkvec(16'd4, 16'd4, 16'd4), 8, 1);
        drain(1'b1, 3, -1, -1);
        fill_exp(16'd40);
        feed(1'b1, mkvec(16'd5, 16'd5, 16'd5), 8, 1);
        drain(1'b1, 0, -1, -1);
        check("b_idle_wrap", 32'(b_out_v), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/conv1_acc_drain.md
# conv1_acc_drain

Downstream stage of the conv1 layer1 dense datapath. It consumes the 64-lane × 16-bit product vector from the 1×64 parallel multiplier and accumulates TAPS products per output pixel with saturation. It snapshots each finished pixel into a drain buffer and serialises the 64 channel results to the conv1 output BRAM writer over a valid/ready port. Accumulation of the next pixel overlaps the drain of the current one.

## Interface
Parameters:
- LANES, 64, output channels per pixel (channel index width fixed at 6)
- DW, 16, lane width, signed two's complement
- TAPS, 75, products accumulated per pixel (25 kernel taps × 3 input channels)
- PIX_AW, 10, pixel index width

Ports:
- clk  in  1  clock
- rst  in  1  reset; rst synchronous, active-low; clock clk
- halt  in  1  global freeze: no accept, no drain handshake, all state held
- in_v  in  1  product vector valid
- in_data  in  LANES*DW  lane k = in_data[16k+15:16k]
- acc_full  out  1  finished pixel waiting for drain buffer; upstream must halt and must not drive in_v
- pix_done  out  1  one-cycle pulse when a pixel enters the drain buffer
- out_v  out  1  output word valid
- out_rdy  in  1  writer ready
- out_data  out  DW  channel result
- out_addr  out  PIX_AW+6  {pixel index, channel index}

## Operation
- Accept = in_v & !halt & !acc_full. Only accepted cycles advance tap_cnt (0..TAPS-1).
- Tap 0: acc[k] <= in[k]. Other taps: acc[k] <= sat(acc[k] + in[k]).
- sat: form a 17-bit sum, clamp to 0x7FFF / 0x8000.
- Final tap (tap_cnt == TAPS-1) accepted, drain FSM free (IDLE, or completing its last handshake on the same edge): shadow[k] <= sat sum, tap_cnt <= 0, drain starts at channel 0, pix_done pulses.
- Final tap accepted, drain busy: acc[k] <= sat sum, tap_cnt <= 0, acc_full <= 1. On the edge of the drain's last handshake: shadow <= acc, acc_full <= 0, pix_done pulses, and the drain restarts at channel 0 with no idle cycle.
- Accepts are blocked while acc_full = 1. If in_v is asserted then, it is ignored and does not count as a tap.
- Drain FSM states:
  - IDLE: out_v = 0.
  - DRAIN: out_v = !halt, out_data = f(shadow[ch]), out_addr = {pix_idx, ch}.
  - On out_v & out_rdy, ch increments. On the handshake at ch == LANES-1: pix_idx increments (wraps 2^PIX_AW-1 -> 0), then the FSM goes to IDLE, or back to DRAIN if a shadow load occurs on that edge.
- out_data and out_addr are held stable while out_v = 1 and out_rdy = 0.
- halt freezes every counter, acc, shadow and the FSM. out_v drops while halt = 1 and returns unchanged when halt deasserts.

## Timing
- Reset (rst = 0 at posedge) sets:
  - out_v = 0, out_data = 0, out_addr = 0, acc_full = 0, pix_done = 0
  - tap_cnt = 0, ch = 0, pix_idx = 0
  - all acc and shadow entries = 0, FSM = IDLE
- Reset mid-drain or mid-accumulation aborts the operation. No out_v until a new pixel completes.
- Latency with the drain free: final tap accepted at edge E. pix_done and the first out_v are high in the cycle after E.
- Drain with out_rdy held 1: exactly LANES cycles per pixel.
- Upstream sustained rate without stall: one pixel per max(TAPS, LANES) cycles. With TAPS = 75 and out_rdy = 1, acc_full never asserts.
- acc_full is registered. It asserts the cycle after the blocked final tap and deasserts the cycle after the shadow load.

## Configuration
- CONV1_RELU_EN defined: f(x) = (x < 0) ? 0 : x (ReLU fused on drain).
- CONV1_RELU_EN undefined: f(x) = x (signed pass-through).
- Accumulation and saturation are identical in both builds.

## Test plan
- Ramp: 75 accepts, every lane = 0x0001, out_rdy = 1 -> pix_done once; 64 words of 0x004B; out_addr 0x000..0x03F.
- Saturation: 75 accepts of lane0 = 0x4000 and lane1 = 0xC000 -> ch0 = 0x7FFF. ch1 = 0 with CONV1_RELU_EN, 0x8000 without.
- Backpressure, TAPS overridden to 8: out_rdy = 0 during pixel 1 drain; pixel 2 final tap -> acc_full = 1 and in_v ignored. Raise out_rdy -> pixel 2 words follow pixel 1's last word back-to-back with addr {1, 0}.
- Halt: halt = 1 for 5 cycles mid-drain at ch = 20, out_rdy = 1 -> out_v = 0 during halt; resumes at ch 20 with no word lost or duplicated.
- Wrap: PIX_AW overridden to 2, run 5 pixels -> pixel 5 out_addr = {0, ch}.
- Reset at ch = 30 -> out_v = 0 next cycle; the next pixel drains from addr 0.
